// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory port arbiter
// Contents: requester indices, arbiter state encoding, cache-facing widths.
package dmem_pkg;

  localparam int DATAPATH_W    = 8;
  localparam int DCACHE_ADDR_W = 4;

  localparam int REQ_P   = 0;
  localparam int REQ_H   = 1;
  localparam int REQ_D   = 2;
  localparam int NUM_REQ = 3;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/age_counter.sv
// rtl/age_counter.sv - saturating wait counter that flags a starved requester
// Ports: clk, rst (async, active-high), inc_i (waited this cycle),
//        clr_i (served or not requesting), urgent_o (count reached MAX_WAIT).
module age_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic urgent_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (inc_i && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign urgent_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the single dcache port between processor, host and display
// Ports: p_* processor load/store, h_* SPI host (with lock), d_* display reads,
//        *_gnt one-cycle grant pulses, *_rvalid qualify the shared rdata_o,
//        mem_* registered dcache port, mem_rdata combinational dcache data,
//        locked_o high while the host owns the port.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DCACHE_ADDR_W,
  parameter int DATA_W   = DATAPATH_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  input  logic              h_req,
  input  logic              h_lock,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic [DATA_W-1:0] rdata_o,
  output logic              p_rvalid,
  output logic              h_rvalid,
  output logic              d_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              locked_o
);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   req, elig, gnt_d, gnt_q, rvalid_q;
  logic                 mem_en_q, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d, rdata_q;
  logic                 lock_hold, h_urgent, d_urgent;

  // A request still high during its own grant cycle is the same transaction.
  assign req  = {d_req, h_req, p_req};
  assign elig = req & ~gnt_q;

  // Lock is released in the same cycle h_lock drops; that cycle arbitrates normally.
  assign lock_hold = (state_q == ST_LOCK) && h_lock;

  always_comb begin
    gnt_d = '0;
    if (lock_hold) begin
      gnt_d[REQ_H] = elig[REQ_H];
    end else if (elig[REQ_H] && h_urgent) begin
      gnt_d[REQ_H] = 1'b1;
    end else if (elig[REQ_D] && d_urgent) begin
      gnt_d[REQ_D] = 1'b1;
    end else if (elig[REQ_P]) begin
      gnt_d[REQ_P] = 1'b1;
    end else if (elig[REQ_H]) begin
      gnt_d[REQ_H] = 1'b1;
    end else if (elig[REQ_D]) begin
      gnt_d[REQ_D] = 1'b1;
    end
  end

  always_comb begin
    state_d = ST_ARB;
    if (lock_hold || (gnt_d[REQ_H] && h_lock)) begin
      state_d = ST_LOCK;
    end
  end

  // Idle cycles keep the last address/data on the port.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (gnt_d[REQ_P]) begin
      mem_we_d    = p_we;
      mem_addr_d  = p_addr;
      mem_wdata_d = p_wdata;
    end else if (gnt_d[REQ_H]) begin
      mem_we_d    = h_we;
      mem_addr_d  = h_addr;
      mem_wdata_d = h_wdata;
    end else if (gnt_d[REQ_D]) begin
      mem_addr_d  = d_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ARB;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mem_en_q    <= |gnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rvalid_q    <= gnt_q & {NUM_REQ{~mem_we_q}};
      if (mem_en_q && !mem_we_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  age_counter #(.MAX_WAIT(MAX_WAIT)) u_h_age (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (elig[REQ_H] & ~gnt_d[REQ_H]),
    .clr_i    (gnt_d[REQ_H] | ~h_req),
    .urgent_o (h_urgent)
  );

  age_counter #(.MAX_WAIT(MAX_WAIT)) u_d_age (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (elig[REQ_D] & ~gnt_d[REQ_D]),
    .clr_i    (gnt_d[REQ_D] | ~d_req),
    .urgent_o (d_urgent)
  );

  assign p_gnt     = gnt_q[REQ_P];
  assign h_gnt     = gnt_q[REQ_H];
  assign d_gnt     = gnt_q[REQ_D];
  assign p_rvalid  = rvalid_q[REQ_P];
  assign h_rvalid  = rvalid_q[REQ_H];
  assign d_rvalid  = rvalid_q[REQ_D];
  assign rdata_o   = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign locked_o  = (state_q == ST_LOCK);

endmodule
